// File: rtl/dsp_out_scaler.sv
// dsp_out_scaler: scales the wide signed (a + b) * c results coming from the
// pre-add/multiply DSP block. Each beat gets a rounding right-shift and is
// saturated to VALUE_WIDTH. The results wait in a small first-word-fall-through
// FIFO behind a valid/ready handshake. A sticky counter records how many
// results were clipped.
module dsp_out_scaler #(
   parameter int VALUE_WIDTH = 32,
   parameter int SHIFT_WIDTH = 7,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                       i_clk,
   input  logic                       i_aresetn,
   input  logic                       i_in_valid,
   output logic                       o_in_ready,
   input  logic [2*VALUE_WIDTH:0]     i_in_data,
   input  logic [SHIFT_WIDTH-1:0]     i_shift,
   output logic                       o_out_valid,
   input  logic                       i_out_ready,
   output logic [VALUE_WIDTH-1:0]     o_out_data,
   output logic                       o_out_sat,
   input  logic                       i_clear_count,
   output logic [15:0]                o_sat_count
);

   localparam int IN_W  = 2*VALUE_WIDTH + 1;
   localparam int EXT_W = 2*VALUE_WIDTH + 2;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;
   localparam int OCC_W = AW + 2;

   localparam logic [SHIFT_WIDTH-1:0] MAX_SHIFT = SHIFT_WIDTH'(2*VALUE_WIDTH);
   localparam logic signed [EXT_W-1:0] ROUND_ONE = EXT_W'(1);
   // Largest and smallest representable output, widened to the working width
   localparam logic signed [EXT_W-1:0] SAT_MAX =
      {{(EXT_W-VALUE_WIDTH+1){1'b0}}, {(VALUE_WIDTH-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_MIN =
      {{(EXT_W-VALUE_WIDTH+1){1'b1}}, {(VALUE_WIDTH-1){1'b0}}};

   // ---------------------------------------------------------------- stage 1
   logic                     s1_valid_reg;
   logic signed [IN_W-1:0]   s1_data_reg;
   logic [SHIFT_WIDTH-1:0]   s1_shift_reg;
   logic                     in_fire;

   // ---------------------------------------------------------------- stage 2
   logic signed [EXT_W-1:0]  ext_value;
   logic signed [EXT_W-1:0]  round_add;
   logic signed [EXT_W-1:0]  rounded_value;
   logic signed [EXT_W-1:0]  shifted_value;
   logic                     sat_hi;
   logic                     sat_lo;
   logic [VALUE_WIDTH-1:0]   scaled_next;
   logic                     s2_valid_reg;
   logic [VALUE_WIDTH-1:0]   s2_data_reg;
   logic                     s2_sat_reg;

   // ---------------------------------------------------------------- FIFO
   logic [VALUE_WIDTH-1:0]   fifo_data_mem [FIFO_DEPTH];
   logic                     fifo_sat_mem  [FIFO_DEPTH];
   logic [AW-1:0]            wr_ptr_reg;
   logic [AW-1:0]            rd_ptr_reg;
   logic [CW-1:0]            count_reg;
   logic [AW-1:0]            head_idx;
   logic                     fifo_push;
   logic                     fifo_pop;
   logic [OCC_W-1:0]         occupancy;
   logic [15:0]              sat_count_reg;

   // Ready only looks at registered occupancy, so a same-cycle pop is never
   // credited and the FIFO cannot overflow even though stage 2 never stalls.
   assign occupancy  = OCC_W'(count_reg) + OCC_W'(s1_valid_reg) + OCC_W'(s2_valid_reg);
   assign o_in_ready = (occupancy < OCC_W'(FIFO_DEPTH)) && i_aresetn;
   assign in_fire    = i_in_valid && o_in_ready;

   // Capture the accepted beat together with its clamped shift amount
   always_ff @(posedge i_clk) begin
      if (!i_aresetn) begin
         s1_valid_reg <= 1'b0;
         s1_data_reg  <= '0;
         s1_shift_reg <= '0;
      end else begin
         s1_valid_reg <= in_fire;
         if (in_fire) begin
            s1_data_reg  <= i_in_data;
            s1_shift_reg <= (i_shift > MAX_SHIFT) ? MAX_SHIFT : i_shift;
         end
      end
   end

   // Round half toward +inf, arithmetic shift, then clip to the output range
   always_comb begin
      ext_value = {s1_data_reg[IN_W-1], s1_data_reg};
      round_add = '0;
      if (s1_shift_reg != '0) begin
         round_add = ROUND_ONE << (s1_shift_reg - SHIFT_WIDTH'(1));
      end
      rounded_value = ext_value + round_add;
      shifted_value = rounded_value >>> s1_shift_reg;
      sat_hi        = shifted_value > SAT_MAX;
      sat_lo        = shifted_value < SAT_MIN;
      if (sat_hi) begin
         scaled_next = SAT_MAX[VALUE_WIDTH-1:0];
      end else if (sat_lo) begin
         scaled_next = SAT_MIN[VALUE_WIDTH-1:0];
      end else begin
         scaled_next = shifted_value[VALUE_WIDTH-1:0];
      end
   end

   // Register the scaled result; it is pushed into the FIFO on the next edge
   always_ff @(posedge i_clk) begin
      if (!i_aresetn) begin
         s2_valid_reg <= 1'b0;
         s2_data_reg  <= '0;
         s2_sat_reg   <= 1'b0;
      end else begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            s2_data_reg <= scaled_next;
            s2_sat_reg  <= sat_hi || sat_lo;
         end
      end
   end

   assign fifo_push   = s2_valid_reg;
   assign o_out_valid = (count_reg != '0);
   assign fifo_pop    = o_out_valid && i_out_ready;

   // When empty, point at the most recently popped slot so the outputs hold
   // their last value; that slot cannot be rewritten until the FIFO refills.
   assign head_idx    = (count_reg == '0) ? (rd_ptr_reg - AW'(1)) : rd_ptr_reg;
   assign o_out_data  = fifo_data_mem[head_idx];
   assign o_out_sat   = fifo_sat_mem[head_idx];

   // FIFO storage; cleared on reset so the outputs read 0 until the first beat
   always_ff @(posedge i_clk) begin
      if (!i_aresetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_mem[i] <= '0;
            fifo_sat_mem[i]  <= 1'b0;
         end
      end else if (fifo_push) begin
         fifo_data_mem[wr_ptr_reg] <= s2_data_reg;
         fifo_sat_mem[wr_ptr_reg]  <= s2_sat_reg;
      end
   end

   // FIFO pointers and fill count; push and pop together leave count unchanged
   always_ff @(posedge i_clk) begin
      if (!i_aresetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (fifo_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (fifo_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg <= count_reg + CW'(fifo_push) - CW'(fifo_pop);
      end
   end

   // Sticky saturation counter; a clear beats a simultaneous increment
   always_ff @(posedge i_clk) begin
      if (!i_aresetn) begin
         sat_count_reg <= '0;
      end else if (i_clear_count) begin
         sat_count_reg <= '0;
      end else if (fifo_push && s2_sat_reg && (sat_count_reg != 16'hFFFF)) begin
         sat_count_reg <= sat_count_reg + 16'd1;
      end
   end

   assign o_sat_count = sat_count_reg;

endmodule

// File: tb/tb_dsp_out_scaler.sv
// tb_dsp_out_scaler: directed and random beats checked against a queue-based
// reference of the scaler's arithmetic and ordering.
module tb_dsp_out_scaler;

   localparam int VW = 32;
   localparam int SW = 7;
   localparam int FD = 4;

   logic              i_clk = 1'b0;
   logic              i_aresetn;
   logic              i_in_valid;
   logic              o_in_ready;
   logic [2*VW:0]     i_in_data;
   logic [SW-1:0]     i_shift;
   logic              o_out_valid;
   logic              i_out_ready;
   logic [VW-1:0]     o_out_data;
   logic              o_out_sat;
   logic              i_clear_count;
   logic [15:0]       o_sat_count;

   always #5 i_clk = ~i_clk;

   dsp_out_scaler #(.VALUE_WIDTH(VW), .SHIFT_WIDTH(SW), .FIFO_DEPTH(FD)) dut (
      .i_clk         (i_clk),
      .i_aresetn     (i_aresetn),
      .i_in_valid    (i_in_valid),
      .o_in_ready    (o_in_ready),
      .i_in_data     (i_in_data),
      .i_shift       (i_shift),
      .o_out_valid   (o_out_valid),
      .i_out_ready   (i_out_ready),
      .o_out_data    (o_out_data),
      .o_out_sat     (o_out_sat),
      .i_clear_count (i_clear_count),
      .o_sat_count   (o_sat_count)
   );

   int checks = 0;
   int errors = 0;

   logic [32:0] exp_q [$];
   logic [32:0] mon_e;
   int          model_sat = 0;
   int          n_pops = 0;
   logic [31:0] last_pop_data = '0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: floor((x + 2^(s-1)) / 2^s) with s clamped to 64, then clip
   function automatic logic [32:0] ref_scale(input logic [64:0] d, input logic [6:0] sh);
      logic signed [127:0] x;
      logic signed [127:0] p;
      int s;
      s = (sh > 7'd64) ? 64 : int'(sh);
      x = {{63{d[64]}}, d};
      p = 128'sd1 <<< s;
      if (s > 0) x = x + (p / 2);
      x = x >>> s;
      if (x > 128'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
      if (x < -128'sd2147483648) return {1'b1, 32'h8000_0000};
      return {1'b0, x[31:0]};
   endfunction

   function automatic logic [64:0] rand_data();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
         0:       return {{49{r[15]}}, r[15:0]};
         1:       return {{25{r[39]}}, r[39:0]};
         2:       return {{9{r[55]}}, r[55:0]};
         default: return r[64:0];
      endcase
   endfunction

   // Scoreboard: handshakes are stable between the falling and rising edge
   always @(negedge i_clk) begin
      if (!i_aresetn) begin
         exp_q.delete();
         model_sat = 0;
      end else begin
         if (o_out_valid && i_out_ready) begin
            n_pops++;
            $display("pop  data=%08h sat=%0d", o_out_data, o_out_sat);
            if (exp_q.size() == 0) begin
               check_val("spurious_pop", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check_val("out_data", o_out_data, mon_e[31:0]);
               check_val("out_sat", o_out_sat, mon_e[32]);
               last_pop_data = mon_e[31:0];
            end
         end
         if (i_in_valid && o_in_ready) begin
            mon_e = ref_scale(i_in_data, i_shift);
            exp_q.push_back(mon_e);
            if (mon_e[32]) model_sat++;
            $display("push data=%017h shift=%0d", i_in_data, i_shift);
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic [64:0] d, input logic [6:0] sh);
      bit acc;
      acc = 1'b0;
      i_in_valid = 1'b1;
      i_in_data  = d;
      i_shift    = sh;
      for (int t = 0; t < 64; t++) begin
         @(negedge i_clk);
         if (o_in_ready) begin
            acc = 1'b1;
            break;
         end
      end
      if (!acc) check_val("send_timeout", 0, 1);
      tick();
   endtask

   task automatic wait_drain(input string tag);
      for (int t = 0; t < 100; t++) begin
         if (exp_q.size() == 0 && !o_out_valid) break;
         tick();
      end
      tick();
      tick();
      check_val(tag, exp_q.size(), 0);
      check_val({tag, "_valid"}, o_out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  acc_cnt;
      int  nxt;
      int  pops_before;
      bit  took;

      i_aresetn     = 1'b0;
      i_in_valid    = 1'b1;
      i_in_data     = rand_data();
      i_shift       = 7'd0;
      i_out_ready   = 1'b1;
      i_clear_count = 1'b0;

      // Reset held with valid asserted
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check_val("rst_out_valid", o_out_valid, 0);
      check_val("rst_out_data", o_out_data, 0);
      check_val("rst_out_sat", o_out_sat, 0);
      check_val("rst_sat_count", o_sat_count, 0);
      check_val("rst_in_ready", o_in_ready, 0);
      @(posedge i_clk);
      #1;
      i_aresetn  = 1'b1;
      i_in_valid = 1'b0;
      @(negedge i_clk);
      check_val("rel_in_ready", o_in_ready, 1);
      repeat (4) tick();
      check_val("rel_no_emit", n_pops, 0);

      // Rounding and latency
      send(65'd35, 7'd2);
      i_in_valid = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      check_val("lat_edge1", o_out_valid, 0);
      @(negedge i_clk);
      check_val("lat_edge2", o_out_valid, 1);
      tick();
      send(-65'sd35, 7'd2);
      send(-65'sd34, 7'd2);
      send(65'd45, 7'd0);
      i_in_valid = 1'b0;
      wait_drain("round_drain");
      check_val("round_last", last_pop_data, 32'd45);
      check_val("round_sat_count", o_sat_count, model_sat);

      // Saturation and clear racing the counter increment
      send(65'sd1 <<< 40, 7'd0);
      send(-(65'sd1 <<< 40), 7'd0);
      send(65'sd1 <<< 40, 7'd9);
      i_in_valid = 1'b0;
      wait_drain("sat_drain");
      check_val("sat_count3", o_sat_count, model_sat);
      send(65'sd1 <<< 40, 7'd0);
      i_in_valid = 1'b0;
      tick();
      i_clear_count = 1'b1;
      tick();
      i_clear_count = 1'b0;
      model_sat = 0;
      wait_drain("clr_drain");
      check_val("clr_count", o_sat_count, model_sat);

      // Backpressure: only FIFO_DEPTH beats absorbed
      i_out_ready = 1'b0;
      nxt         = 1;
      acc_cnt     = 0;
      i_in_valid  = 1'b1;
      i_in_data   = 65'd1;
      i_shift     = 7'd0;
      for (int c = 0; c < 10; c++) begin
         @(negedge i_clk);
         took = o_in_ready;
         tick();
         if (took) begin
            acc_cnt++;
            nxt++;
            i_in_data = 65'(nxt);
         end
      end
      check_val("bp_accepted", acc_cnt, FD);
      @(negedge i_clk);
      check_val("bp_in_ready", o_in_ready, 0);
      check_val("bp_head", o_out_data, 1);
      tick();
      i_out_ready = 1'b1;
      for (int c = 0; c < 50 && nxt <= 8; c++) begin
         @(negedge i_clk);
         took = o_in_ready;
         tick();
         if (took) begin
            nxt++;
            i_in_data = 65'(nxt);
         end
      end
      i_in_valid = 1'b0;
      check_val("bp_all_sent", nxt, 9);
      wait_drain("bp_drain");
      check_val("bp_last", last_pop_data, 8);
      check_val("fwft_hold", o_out_data, 8);

      // Shift clamp
      send({65{1'b1}}, 7'd127);
      send(65'h1_0000_0000_0000_0000, 7'd64);
      send(65'h1_8000_0000_0000_0000, 7'd64);
      send(65'h0_7FFF_FFFF_FFFF_FFFF, 7'd100);
      i_in_valid = 1'b0;
      wait_drain("clamp_drain");

      // Random traffic with random backpressure
      i_in_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge i_clk);
         took = i_in_valid && o_in_ready;
         tick();
         i_out_ready = ($urandom_range(0, 3) != 0);
         if (took || !i_in_valid) begin
            if ($urandom_range(0, 3) != 0) begin
               i_in_valid = 1'b1;
               i_in_data  = rand_data();
               i_shift    = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                         : 7'($urandom_range(0, 40));
            end else begin
               i_in_valid = 1'b0;
            end
         end
      end
      i_in_valid  = 1'b0;
      i_out_ready = 1'b1;
      wait_drain("rand_drain");
      check_val("rand_sat_count", o_sat_count, model_sat);

      // Reset with beats in flight and buffered
      i_out_ready = 1'b0;
      send(65'd11, 7'd0);
      send(65'd12, 7'd0);
      send(65'd13, 7'd0);
      send(65'd14, 7'd0);
      i_in_valid = 1'b0;
      i_aresetn  = 1'b0;
      tick();
      i_aresetn = 1'b1;
      @(negedge i_clk);
      check_val("mid_out_valid", o_out_valid, 0);
      check_val("mid_out_data", o_out_data, 0);
      check_val("mid_sat_count", o_sat_count, 0);
      check_val("mid_in_ready", o_in_ready, 1);
      tick();
      i_out_ready = 1'b1;
      pops_before = n_pops;
      repeat (6) tick();
      check_val("mid_no_stale", n_pops, pops_before);
      send(65'd7, 7'd0);
      i_in_valid = 1'b0;
      wait_drain("mid_drain");
      check_val("mid_one_pop", n_pops, pops_before + 1);
      check_val("mid_value", last_pop_data, 7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
